flow_stats_poller: RTL and testbench
====================================

Name: flow_stats_poller

Overview:
Read-side master for the per-flow packet-size accumulator. It sweeps a programmable range of flow numbers and issues one read strobe per flow. It captures each returned count, which the accumulator clears on read, and emits {flow, count} records on a valid/ready stream through a small output FIFO. It sits between the accumulator's rd_stb/rd_flow_num/rd_data/rd_data_val port and the statistics export path.

Parameters:
A_WIDTH, 10, flow-number width; flows 0..2**A_WIDTH-1
D_WIDTH, 32, count width; matches accumulator data width
TIMEOUT, 15, max cycles in WAIT before a read is abandoned (>= 8)
FIFO_DEPTH, 4, output record FIFO depth (power of two, >= 2)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous, active-low reset (0 = reset)
start_i  in  1  pulse: begin a sweep (ignored while busy_o=1)
first_flow_i  in  A_WIDTH  first flow of sweep, sampled on accepted start_i
last_flow_i  in  A_WIDTH  last flow of sweep (inclusive), sampled on accepted start_i
skip_zero_i  in  1  1 = drop records with count 0, sampled on accepted start_i
rd_stb_o  out  1  single-cycle read strobe to accumulator
rd_flow_num_o  out  A_WIDTH  flow being read, valid with rd_stb_o
rd_data_i  in  D_WIDTH  accumulator read data
rd_data_val_i  in  1  accumulator read-valid (may be a level or a pulse)
rec_valid_o  out  1  record available
rec_ready_i  in  1  downstream accepts record
rec_flow_o  out  A_WIDTH  record flow number
rec_count_o  out  D_WIDTH  record count
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse after the last flow of a sweep is processed
timeout_cnt_o  out  8  saturating count of abandoned reads since reset

Behaviour:
- Reset (rst_i=0 at clock edge): FSM=IDLE, FIFO flushed. rd_stb_o=0, rd_flow_num_o=0, rec_valid_o=0, busy_o=0, done_o=0, timeout_cnt_o=0. Reset mid-sweep abandons the sweep with no done_o. An in-flight accumulator response arriving after reset is ignored by the edge rule.
- FSM states: IDLE, ISSUE, WAIT, STORE, NEXT.
- IDLE: on start_i=1, latch cur=first_flow_i, last, skip; busy_o=1; go to ISSUE.
- ISSUE: if FIFO has >= 1 free entry, drive rd_stb_o=1 and rd_flow_num_o=cur for exactly one cycle, clear the wait timer, go to WAIT. Otherwise stall in ISSUE with no strobe.
- Only one read is outstanding at a time.
- WAIT: a register holds rd_data_val_i delayed by one cycle. Data is accepted on the first cycle in WAIT where rd_data_val_i=1 and the delayed value is 0 (rising edge). This makes stale level-valid from a previous read harmless.
  - On accept: capture rd_data_i, go to STORE.
  - After TIMEOUT cycles in WAIT with no accept: timeout_cnt_o increments (saturates at 255), no record is produced, go to NEXT.
- Nominal accumulator latency is 4 cycles from strobe to valid.
- STORE: push {cur, data} into the FIFO unless skip=1 and data=0; then go to NEXT. A free slot is guaranteed because ISSUE checked for one.
- NEXT:
  - If cur==last: done_o=1 for one cycle, busy_o=0, go to IDLE.
  - Else: cur=cur+1 modulo 2**A_WIDTH, go to ISSUE.
  - Wrap-around: last<first sweeps through the maximum flow back to 0. first==last reads exactly one flow.
- A full sweep over all flows uses first=F, last=F-1 mod 2**A_WIDTH.
- Output stream: rec_valid_o=FIFO non-empty. Pop when rec_valid_o && rec_ready_i. rec_flow_o/rec_count_o hold stable while valid && !ready.
- FIFO allows simultaneous push and pop when full-minus-pop. FIFO contents persist after done_o until drained.
- start_i while busy_o=1 is ignored; no queuing.
- rd_data_val_i outside WAIT is ignored, but still updates the delayed register.
- Minimum per-flow period is 1 (ISSUE) + 4 (accumulator latency) + 1 (STORE) + 1 (NEXT) = 7 cycles.

Decomposition:
- Shared package flow_stats_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, STORE, NEXT)
  - record struct {flow, count} parameterised by A_WIDTH/D_WIDTH
  - default TIMEOUT constant
- One sub-module: stats_rec_fifo, a synchronous FIFO of records with full/empty/free-slot flags, using the same active-low synchronous reset.

Test Plan:
- Preload flows 3,4,5 of the accumulator with 7,0,12. Sweep first=3, last=5, skip=0, rec_ready=1 -> records (3,7),(4,0),(5,12) in order. done_o pulses once. Re-reading flow 3 returns 0.
- Same preload, skip=1 -> only (3,7),(5,12). done_o still pulses after flow 5.
- A_WIDTH=4, first=14, last=1 -> strobes to flows 14,15,0,1 exactly, four strobes total.
- Hold rec_ready=0 over a sweep of 8 flows, all counts nonzero -> exactly 4 strobes, then no strobe while the FIFO is full. Record data stays stable. Releasing rec_ready drains the FIFO and the sweep completes with 8 records.
- Accumulator model never asserts valid for flow 2 -> no record for flow 2, timeout_cnt_o=1, sweep continues to flow 3 after 15 WAIT cycles.
- Assert rst_i=0 for one cycle while in WAIT mid-sweep -> all outputs return to reset values next cycle, no done_o. The late valid is ignored, and a new start_i works normally.

Source files
------------

// File: rtl/flow_stats_pkg.sv
// Shared types and defaults for the flow statistics poller.
// The record layout is also re-declared inside the poller using its own A_WIDTH/D_WIDTH.
package flow_stats_pkg;

  localparam int unsigned DEF_A_WIDTH = 10;
  localparam int unsigned DEF_D_WIDTH = 32;
  localparam int unsigned DEF_TIMEOUT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_NEXT
  } state_e;

  // Record layout at the default widths; the poller builds the same shape from its own parameters.
  typedef struct packed {
    logic [DEF_A_WIDTH-1:0] flow;
    logic [DEF_D_WIDTH-1:0] count;
  } flow_rec_t;

endpackage

// File: rtl/flow_stats_poller_fifo.sv
// Small synchronous record FIFO for the stats poller.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module stats_rec_fifo #(
  parameter int unsigned WIDTH = 42,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, do_pop};
    data_o   = mem_q[rd_ptr_q[PW-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/flow_stats_poller.sv
// Sweeps a flow range on the accumulator read port, one outstanding read at a time,
// and streams {flow, count} records out through a small FIFO.
module flow_stats_poller
  import flow_stats_pkg::*;
#(
  parameter int unsigned A_WIDTH    = DEF_A_WIDTH,
  parameter int unsigned D_WIDTH    = DEF_D_WIDTH,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [A_WIDTH-1:0] first_flow_i,
  input  logic [A_WIDTH-1:0] last_flow_i,
  input  logic               skip_zero_i,
  output logic               rd_stb_o,
  output logic [A_WIDTH-1:0] rd_flow_num_o,
  input  logic [D_WIDTH-1:0] rd_data_i,
  input  logic               rd_data_val_i,
  output logic               rec_valid_o,
  input  logic               rec_ready_i,
  output logic [A_WIDTH-1:0] rec_flow_o,
  output logic [D_WIDTH-1:0] rec_count_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [7:0]         timeout_cnt_o
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic [A_WIDTH-1:0] flow;
    logic [D_WIDTH-1:0] count;
  } rec_t;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   cur_q, cur_d;
  logic [A_WIDTH-1:0]   last_q, last_d;
  logic                 skip_q, skip_d;
  logic [D_WIDTH-1:0]   data_q, data_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           to_cnt_q, to_cnt_d;
  logic                 rd_stb_q, rd_stb_d;
  logic [A_WIDTH-1:0]   rd_flow_q, rd_flow_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 val_dly_q;

  logic                 push;
  logic                 fifo_empty, fifo_full;
  rec_t                 rec_in, rec_out;

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    last_d    = last_q;
    skip_d    = skip_q;
    data_d    = data_q;
    timer_d   = timer_q;
    to_cnt_d  = to_cnt_q;
    rd_stb_d  = 1'b0;
    rd_flow_d = rd_flow_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cur_d   = first_flow_i;
          last_d  = last_flow_i;
          skip_d  = skip_zero_i;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!fifo_full) begin
          rd_stb_d  = 1'b1;
          rd_flow_d = cur_q;
          timer_d   = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Rising edge only, so a level-valid left high by the previous read is not taken.
        if (rd_data_val_i && !val_dly_q) begin
          data_d  = rd_data_i;
          state_d = ST_STORE;
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          if (to_cnt_q != '1) to_cnt_d = to_cnt_q + 8'd1;
          state_d = ST_NEXT;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_STORE: begin
        push    = !(skip_q && (data_q == '0));
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (cur_q == last_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cur_d   = cur_q + A_WIDTH'(1);
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      last_q    <= '0;
      skip_q    <= 1'b0;
      data_q    <= '0;
      timer_q   <= '0;
      to_cnt_q  <= '0;
      rd_stb_q  <= 1'b0;
      rd_flow_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      val_dly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      skip_q    <= skip_d;
      data_q    <= data_d;
      timer_q   <= timer_d;
      to_cnt_q  <= to_cnt_d;
      rd_stb_q  <= rd_stb_d;
      rd_flow_q <= rd_flow_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      val_dly_q <= rd_data_val_i;
    end
  end

  assign rec_in = '{flow: cur_q, count: data_q};

  stats_rec_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (rec_in),
    .pop_i   (rec_valid_o && rec_ready_i),
    .data_o  (rec_out),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rd_stb_o      = rd_stb_q;
  assign rd_flow_num_o = rd_flow_q;
  assign rec_valid_o   = !fifo_empty;
  assign rec_flow_o    = rec_out.flow;
  assign rec_count_o   = rec_out.count;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_cnt_o = to_cnt_q;

endmodule

// File: tb/tb_flow_stats_poller.sv
// Bench for flow_stats_poller: accumulator model driving the read port, sweep-level
// reference model of strobes/records/timeouts, and a per-cycle compare process.
module tb_flow_stats_poller;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 15;
  localparam int unsigned FD = 4;
  localparam int unsigned NF = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] first_flow_i = '0;
  logic [AW-1:0] last_flow_i = '0;
  logic          skip_zero_i = 1'b0;
  logic          rd_stb_o;
  logic [AW-1:0] rd_flow_num_o;
  logic [DW-1:0] rd_data_i = '0;
  logic          rd_data_val_i = 1'b0;
  logic          rec_valid_o;
  logic          rec_ready_i = 1'b0;
  logic [AW-1:0] rec_flow_o;
  logic [DW-1:0] rec_count_o;
  logic          busy_o;
  logic          done_o;
  logic [7:0]    timeout_cnt_o;

  flow_stats_poller #(
    .A_WIDTH    (AW),
    .D_WIDTH    (DW),
    .TIMEOUT    (TO),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .first_flow_i  (first_flow_i),
    .last_flow_i   (last_flow_i),
    .skip_zero_i   (skip_zero_i),
    .rd_stb_o      (rd_stb_o),
    .rd_flow_num_o (rd_flow_num_o),
    .rd_data_i     (rd_data_i),
    .rd_data_val_i (rd_data_val_i),
    .rec_valid_o   (rec_valid_o),
    .rec_ready_i   (rec_ready_i),
    .rec_flow_o    (rec_flow_o),
    .rec_count_o   (rec_count_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Accumulator model: clear-on-read memory, valid after a latency, held 1..3 cycles.
  logic [DW-1:0] acc_mem [NF];
  bit            no_resp [NF];
  logic [DW-1:0] acc_pend;
  int            acc_cnt = 0;
  int            acc_hold = 0;
  int            lat_fixed = 4;
  bit            lat_rand = 1'b0;

  always @(negedge clk) begin
    if (acc_hold > 0) begin
      acc_hold--;
      if (acc_hold == 0) rd_data_val_i = 1'b0;
    end
    if (acc_cnt > 0) begin
      acc_cnt--;
      if (acc_cnt == 0) begin
        rd_data_val_i = 1'b1;
        rd_data_i     = acc_pend;
        acc_hold      = $urandom_range(1, 3);
      end
    end
    if (rd_stb_o === 1'b1 && !no_resp[rd_flow_num_o]) begin
      acc_pend = acc_mem[rd_flow_num_o];
      acc_mem[rd_flow_num_o] = '0;
      acc_cnt = lat_rand ? int'($urandom_range(2, 8)) - 1 : lat_fixed - 1;
    end
  end

  // Reference model state: expected strobe order, expected records, timeouts.
  int unsigned model_mem [NF];
  int          model_to = 0;
  int          exp_stb [$];
  int          exp_rf [$];
  int          exp_rc [$];
  int          stb_log [$];
  int unsigned stb_cyc [$];
  int          rec_log_f [$];
  int          rec_log_c [$];
  int          done_cnt = 0;
  int          ready_mode = 0;

  bit            prev_stb = 0, prev_done = 0, prev_hold = 0;
  logic [AW-1:0] hold_f;
  logic [DW-1:0] hold_c;

  always @(negedge clk) begin
    if (!rst_i) begin
      prev_stb  = 0;
      prev_done = 0;
      prev_hold = 0;
    end else begin
      case (ready_mode)
        0:       rec_ready_i = 1'b1;
        1:       rec_ready_i = 1'b0;
        default: rec_ready_i = ($urandom_range(0, 9) < 7);
      endcase
      if (rd_stb_o) begin
        chk("stb_pulse", prev_stb, 0);
        if (exp_stb.size() == 0) fail("stb_unexpected", $sformatf("strobe to flow %0d", rd_flow_num_o));
        else chk("stb_flow", rd_flow_num_o, exp_stb.pop_front());
        stb_log.push_back(int'(rd_flow_num_o));
        stb_cyc.push_back(cyc);
      end
      if (prev_hold) begin
        chk("rec_hold_valid", rec_valid_o, 1);
        chk("rec_hold_flow", rec_flow_o, hold_f);
        chk("rec_hold_count", rec_count_o, hold_c);
      end
      if (rec_valid_o && rec_ready_i) begin
        if (exp_rf.size() == 0) fail("rec_unexpected", $sformatf("flow %0d count %0d", rec_flow_o, rec_count_o));
        else begin
          chk("rec_flow", rec_flow_o, exp_rf.pop_front());
          chk("rec_count", rec_count_o, exp_rc.pop_front());
        end
        rec_log_f.push_back(int'(rec_flow_o));
        rec_log_c.push_back(int'(rec_count_o));
      end
      prev_hold = rec_valid_o && !rec_ready_i;
      hold_f    = rec_flow_o;
      hold_c    = rec_count_o;
      if (done_o) begin
        done_cnt++;
        chk("done_pulse", prev_done, 0);
      end
      prev_stb  = rd_stb_o;
      prev_done = done_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input int f, input int unsigned v);
    acc_mem[f]   = DW'(v);
    model_mem[f] = v;
  endtask

  task automatic plan(input int f, input int l, input bit sk);
    int x = f;
    forever begin
      exp_stb.push_back(x);
      if (no_resp[x]) begin
        if (model_to < 255) model_to++;
      end else begin
        int unsigned c = model_mem[x];
        model_mem[x] = 0;
        if (!(sk && c == 0)) begin
          exp_rf.push_back(x);
          exp_rc.push_back(int'(c));
        end
      end
      if (x == l) break;
      x = (x + 1) % NF;
    end
  endtask

  task automatic start_sweep(input int f, input int l, input bit sk);
    plan(f, l, sk);
    first_flow_i = AW'(f);
    last_flow_i  = AW'(l);
    skip_zero_i  = sk;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
  endtask

  task automatic finish_sweep(input int base_done);
    int n = 0;
    while (done_cnt == base_done && n < 1000) begin tick(); n++; end
    if (done_cnt == base_done) fail("sweep_done_timeout", "done_o never pulsed");
    n = 0;
    while (exp_rf.size() != 0 && n < 200) begin tick(); n++; end
    tick();
    chk("records_drained", exp_rf.size(), 0);
    chk("strobes_all_seen", exp_stb.size(), 0);
    chk("done_count", done_cnt - base_done, 1);
    chk("busy_after_done", busy_o, 0);
    chk("timeout_cnt", timeout_cnt_o, model_to);
  endtask

  task automatic run_sweep(input int f, input int l, input bit sk);
    int bd = done_cnt;
    start_sweep(f, l, sk);
    finish_sweep(bd);
  endtask

  task automatic chk_rec(input int idx, input int f, input int c);
    if (idx < rec_log_f.size()) begin
      chk("pin_rec_flow", rec_log_f[idx], f);
      chk("pin_rec_count", rec_log_c[idx], c);
    end else fail("pin_rec_missing", $sformatf("record %0d not seen", idx));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rd_stb", rd_stb_o, 0);
    chk("rst_rd_flow", rd_flow_num_o, 0);
    chk("rst_rec_valid", rec_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_timeout_cnt", timeout_cnt_o, 0);
  endtask

  initial begin
    int rb, sb, bd, n;
    for (int i = 0; i < int'(NF); i++) begin
      preload(i, 0);
      no_resp[i] = 0;
    end
    repeat (3) tick();
    chk_reset_outputs();
    rst_i = 1'b1;
    tick();

    // Basic sweep 3..5, then re-read of the cleared flow 3.
    preload(3, 7); preload(4, 0); preload(5, 12);
    rb = rec_log_f.size(); sb = stb_log.size();
    run_sweep(3, 5, 0);
    chk("basic_records", rec_log_f.size() - rb, 3);
    chk_rec(rb, 3, 7); chk_rec(rb + 1, 4, 0); chk_rec(rb + 2, 5, 12);
    if (stb_cyc.size() >= sb + 2) chk("per_flow_period", stb_cyc[sb+1] - stb_cyc[sb], 7);
    else fail("per_flow_period", "strobes missing");
    rb = rec_log_f.size();
    run_sweep(3, 3, 0);
    chk_rec(rb, 3, 0);

    // Skip-zero drops flow 4.
    preload(3, 7); preload(4, 0); preload(5, 12);
    rb = rec_log_f.size();
    run_sweep(3, 5, 1);
    chk("skip_records", rec_log_f.size() - rb, 2);
    chk_rec(rb, 3, 7); chk_rec(rb + 1, 5, 12);

    // Wrap-around sweep 14..1.
    preload(14, 21); preload(15, 22); preload(0, 23); preload(1, 24);
    sb = stb_log.size();
    run_sweep(14, 1, 0);
    chk("wrap_strobes", stb_log.size() - sb, 4);
    if (stb_log.size() >= sb + 4) begin
      chk("wrap_flow0", stb_log[sb], 14);   chk("wrap_flow1", stb_log[sb+1], 15);
      chk("wrap_flow2", stb_log[sb+2], 0);  chk("wrap_flow3", stb_log[sb+3], 1);
    end

    // Flow 2 never answers: abandoned after the WAIT window.
    preload(1, 5); preload(2, 6); preload(3, 9);
    no_resp[2] = 1;
    rb = rec_log_f.size(); sb = stb_log.size();
    run_sweep(1, 3, 0);
    no_resp[2] = 0;
    chk("timeout_pin", timeout_cnt_o, 1);
    chk("timeout_records", rec_log_f.size() - rb, 2);
    if (stb_cyc.size() >= sb + 3) begin
      chk("gap_normal", stb_cyc[sb+1] - stb_cyc[sb], 7);
      chk("gap_timeout", stb_cyc[sb+2] - stb_cyc[sb+1], 17);
    end else fail("timeout_gaps", "strobes missing");
    acc_mem[2] = '0; model_mem[2] = 0;

    // Downstream stalled: FIFO fills, issue stops at 4 strobes.
    for (int i = 0; i < 8; i++) preload(i, 100 + i * 3);
    ready_mode = 1;
    bd = done_cnt; rb = rec_log_f.size(); sb = stb_log.size();
    start_sweep(0, 7, 0);
    repeat (80) tick();
    chk("stall_strobes", stb_log.size() - sb, 4);
    chk("stall_busy", busy_o, 1);
    chk("stall_valid", rec_valid_o, 1);
    ready_mode = 0;
    finish_sweep(bd);
    chk("stall_records", rec_log_f.size() - rb, 8);

    // Reset while waiting on a read.
    for (int i = 0; i < 6; i++) preload(i, 40 + i);
    bd = done_cnt; sb = stb_log.size();
    start_sweep(0, 5, 0);
    n = 0;
    while (stb_log.size() < sb + 2 && n < 100) begin tick(); n++; end
    tick();
    rst_i = 1'b0;
    tick();
    chk_reset_outputs();
    rst_i = 1'b1;
    exp_stb.delete(); exp_rf.delete(); exp_rc.delete();
    model_to = 0;
    for (int i = 0; i < int'(NF); i++) model_mem[i] = acc_mem[i];
    repeat (12) tick();
    chk("no_done_after_reset", done_cnt, bd);
    run_sweep(2, 4, 0);

    // Randomized sweeps.
    ready_mode = 2;
    lat_rand   = 1'b1;
    for (int it = 0; it < 14; it++) begin
      int f, len;
      for (int i = 0; i < int'(NF); i++) begin
        preload(i, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 65535));
        no_resp[i] = ($urandom_range(0, 9) == 0);
      end
      f   = $urandom_range(0, NF - 1);
      len = $urandom_range(1, 10);
      run_sweep(f, (f + len - 1) % NF, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
